axi_sim_mem: RTL
================

Name: axi_sim_mem

Overview:
- Parametrised AXI4 slave memory model for the NPC simulation top. It is the next generation of the DPI-backed sim SRAM.
- Holds an internal byte-addressable array, so no DPI is needed on the data path.
- Read and write paths are independent state machines, so the two directions proceed concurrently.
- Adds configurable data width, read latency, FIXED/INCR/WRAP bursts, narrow transfers, and SLVERR reporting.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width; must be 32 or 64.
- ID_W, 4, AXI ID width.
- MEM_BYTES, 65536, array size in bytes; must be a power of two.
- BASE_ADDR, 32'h8000_0000, first mapped byte address.
- RD_LAT, 1, cycles from AR handshake to first rvalid; must be >=1.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- arid  in  ID_W  read ID
- araddr  in  ADDR_W  read start address
- arlen  in  8  read beats-1
- arsize  in  3  read bytes/beat = 1<<arsize
- arburst  in  2  read burst type: 00 FIXED, 01 INCR, 10 WRAP
- arvalid  in  1 / arready  out  1  AR handshake
- rid  out  ID_W / rdata  out  DATA_W / rresp  out  2 / rlast  out  1  read beat
- rvalid  out  1 / rready  in  1  R handshake
- awid  in  ID_W / awaddr  in  ADDR_W / awlen  in  8 / awsize  in  3 / awburst  in  2  write address, same encoding as AR
- awvalid  in  1 / awready  out  1  AW handshake
- wdata  in  DATA_W / wstrb  in  DATA_W/8 / wlast  in  1  write beat
- wvalid  in  1 / wready  out  1  W handshake
- bid  out  ID_W / bresp  out  2  write response
- bvalid  out  1 / bready  in  1  B handshake

Behaviour:
- Reset (async, areset=1):
  - All outputs go to 0; both FSMs go to IDLE; counters and error flags clear.
  - Array contents are retained.
  - arready/awready stay 0 for the first cycle after release, then follow state.
- Reset mid-burst: the transaction is abandoned and no bvalid is issued. Writes already committed remain.
- Read FSM RD_IDLE -> RD_WAIT -> RD_DATA:
  - RD_IDLE: arready=1. On arvalid&arready, capture id/addr/len/size/burst, set beat count=0, latch error, go to RD_WAIT.
  - RD_WAIT: latency counter runs; after RD_LAT-1 cycles, load the first beat and go to RD_DATA. Result: rvalid rises exactly RD_LAT cycles after the AR handshake.
  - RD_DATA: rvalid=1. rdata, rresp, rlast are stable until rvalid&rready. Each handshake advances the address and loads the next beat (back-to-back, no bubble).
  - rlast=1 on beat count==len. Handshake of the last beat returns to RD_IDLE; arready rises the next cycle.
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP:
  - WR_IDLE: awready=1, wready=0. On the AW handshake, capture fields and go to WR_DATA.
  - WR_DATA: wready=1. Each W handshake writes the bytes whose wstrb bit is set into the aligned word, then advances the address.
  - On handshake of beat count==len, go to WR_RESP.
  - WR_RESP: bvalid=1 with bid=captured awid. Hold until bready, then go to WR_IDLE.
  - W beats arriving before the AW handshake are not accepted (wready=0).
- Address sequencing, with step = 1<<size:
  - FIXED: address is constant.
  - INCR: addr += step.
  - WRAP: bytes = (len+1)*step; next = (addr & ~(bytes-1)) | ((addr+step) & (bytes-1)).
- Word index = ((addr-BASE_ADDR) mod MEM_BYTES) >> log2(DATA_W/8).
- rdata always carries the full aligned word; narrow lanes are selected by the master.
- wstrb is applied as given, not masked by size.
- Errors set resp=2'b10 (SLVERR) for the whole burst. Causes:
  - address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES);
  - burst==11;
  - size > log2(DATA_W/8);
  - WRAP with len not in {1,3,7,15} or an unaligned start address.
- Under an error, reads return 0 and writes are suppressed. The beat count still runs to len and the handshakes complete normally.
- wlast mismatch (asserted before the final beat, or missing on it) forces bresp=SLVERR. Beat count, not wlast, ends the burst.
- Simultaneous read and write to the same word at the same edge: the read loads the old data (read-before-write).
- Beat counters are 8-bit; len=255 gives 256 beats with no wrap-around error.

Test Plan:
- INCR read: preload 0x8000_0000..+31 with bytes 0x00..0x1F; AR len=3, size=3, DATA_W=64, RD_LAT=3 -> rvalid exactly 3 cycles after handshake; rdata 0x0706050403020100, 0x0F0E0D0C0B0A0908, ...; rlast only on beat 4; rresp=0.
- WRAP write+read: AW addr 0x8000_0018, len=3, size=3; wdata 0xA..0xD; wstrb 0xFF -> words 0x18,0x00,0x08,0x10 receive A,B,C,D; bresp=0, bid=awid. A following INCR read from 0x8000_0000 returns B,C,D,A.
- Narrow/strobe write: size=0, wstrb=0x04, wdata=0x00FF0000 at 0x8000_0002 -> only byte 2 changes to 0xFF.
- Error cases:
  - read at 0x7FFF_FFF8 -> rresp=2'b10, rdata=0, len+1 beats;
  - write with burst=11 -> memory unchanged, bresp=2'b10;
  - wlast on beat 2 of 4 -> bresp=2'b10 after beat 4.
- Backpressure and concurrency: rready toggles 1/0 every cycle during a len=7 read while an independent 4-beat write runs -> rdata stable while stalled, all 8 beats correct, write completes concurrently.
- Reset mid-burst: assert areset during beat 2 of a write -> rvalid/bvalid/arready/awready go 0 immediately; after release, beat 1 data persists, no bvalid is issued, and a new AR is accepted 2 cycles after release.

Source files
------------

// File: rtl/axi_sim_mem.sv
// axi_sim_mem: AXI4 slave memory model with an internal byte-addressable array.
// Read and write channels run independent FSMs so both directions proceed concurrently.
`timescale 1ns/1ps
module axi_sim_mem #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter int unsigned       RD_LAT    = 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_W-1:0]       arid,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ID_W-1:0]       awid,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned LANE_W   = $clog2(STRB_W);
    localparam int unsigned MEM_AW   = $clog2(MEM_BYTES);
    localparam int unsigned IDX_W    = MEM_AW - LANE_W;
    localparam int unsigned WORDS    = MEM_BYTES / STRB_W;
    localparam logic [15:0] LAT_LAST = 16'(RD_LAT - 1);
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    rd_state_t rd_state, rd_next_state;
    wr_state_t wr_state, wr_next_state;
    logic      started;

    logic [DATA_W-1:0] mem [WORDS];

    logic [ID_W-1:0]   rd_id;
    logic [ADDR_W-1:0] rd_addr, rd_step_addr;
    logic [7:0]        rd_len, rd_cnt;
    logic [2:0]        rd_size;
    logic [1:0]        rd_burst;
    logic              rd_err;
    logic [15:0]       lat_cnt;

    logic [ID_W-1:0]   wr_id;
    logic [ADDR_W-1:0] wr_addr, wr_step_addr;
    logic [7:0]        wr_len, wr_cnt;
    logic [2:0]        wr_size;
    logic [1:0]        wr_burst;
    logic              wr_err, wlast_err;
    logic [IDX_W-1:0]  wr_idx;
    logic              mem_we;

    // Word index wraps modulo the array size.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> LANE_W);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] step, mask, nxt;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b00:   nxt = addr;
            2'b10:   nxt = (addr & ~mask) | ((addr + step) & mask);
            default: nxt = addr + step;
        endcase
        return nxt;
    endfunction

    function automatic logic burst_err(input logic [ADDR_W-1:0] addr,
                                       input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic [ADDR_W-1:0] off, step;
        logic err;
        off  = addr - BASE_ADDR;
        step = ADDR_W'(1) << size;
        err  = (off >= ADDR_W'(MEM_BYTES)) || (burst == 2'b11) || (size > 3'(LANE_W));
        if (burst == 2'b10) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
                err = 1'b1;
            if ((addr & (step - ADDR_W'(1))) != '0)
                err = 1'b1;
        end
        return err;
    endfunction

    // State registers; started holds the ready outputs low for one cycle after reset release.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
            started  <= 1'b0;
        end else begin
            rd_state <= rd_next_state;
            wr_state <= wr_next_state;
            started  <= 1'b1;
        end
    end

    // Read FSM next state.
    always_comb begin
        rd_next_state = rd_state;
        case (rd_state)
            RD_IDLE: if (arvalid && arready)        rd_next_state = RD_WAIT;
            RD_WAIT: if (lat_cnt == LAT_LAST)       rd_next_state = RD_DATA;
            RD_DATA: if (rready && rd_cnt == rd_len) rd_next_state = RD_IDLE;
            default:                                 rd_next_state = RD_IDLE;
        endcase
    end

    // Write FSM next state; beat count, not wlast, ends the burst.
    always_comb begin
        wr_next_state = wr_state;
        case (wr_state)
            WR_IDLE: if (awvalid && awready)         wr_next_state = WR_DATA;
            WR_DATA: if (wvalid && wr_cnt == wr_len) wr_next_state = WR_RESP;
            WR_RESP: if (bready)                     wr_next_state = WR_IDLE;
            default:                                 wr_next_state = WR_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        arready = started && (rd_state == RD_IDLE);
        rvalid  = (rd_state == RD_DATA);
        awready = started && (wr_state == WR_IDLE);
        wready  = (wr_state == WR_DATA);
        bvalid  = (wr_state == WR_RESP);
    end

    // Burst address stepping and write enable.
    always_comb begin
        rd_step_addr = next_addr(rd_addr, rd_len, rd_size, rd_burst);
        wr_step_addr = next_addr(wr_addr, wr_len, wr_size, wr_burst);
        wr_idx       = word_idx(wr_addr);
        mem_we       = wready && wvalid && !wr_err;
    end

    // Read datapath: capture AR, count latency, load each beat ahead of its handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_id    <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
            rd_err   <= 1'b0;
            lat_cnt  <= '0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
            rlast    <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: if (arvalid && arready) begin
                    rd_id    <= arid;
                    rd_addr  <= araddr;
                    rd_len   <= arlen;
                    rd_size  <= arsize;
                    rd_burst <= arburst;
                    rd_cnt   <= '0;
                    rd_err   <= burst_err(araddr, arlen, arsize, arburst);
                    lat_cnt  <= '0;
                end
                RD_WAIT: if (lat_cnt == LAT_LAST) begin
                    rid   <= rd_id;
                    rdata <= rd_err ? '0 : mem[word_idx(rd_addr)];
                    rresp <= rd_err ? SLVERR : OKAY;
                    rlast <= (rd_len == 8'd0);
                end else begin
                    lat_cnt <= lat_cnt + 16'd1;
                end
                RD_DATA: if (rready) begin
                    if (rd_cnt == rd_len) begin
                        rlast <= 1'b0;
                    end else begin
                        rd_addr <= rd_step_addr;
                        rd_cnt  <= rd_cnt + 8'd1;
                        rdata   <= rd_err ? '0 : mem[word_idx(rd_step_addr)];
                        rlast   <= (rd_cnt + 8'd1 == rd_len);
                    end
                end
                default: ;
            endcase
        end
    end

    // Write datapath: capture AW, track beats and wlast consistency, form the response.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_id     <= '0;
            wr_addr   <= '0;
            wr_len    <= '0;
            wr_size   <= '0;
            wr_burst  <= '0;
            wr_cnt    <= '0;
            wr_err    <= 1'b0;
            wlast_err <= 1'b0;
            bid       <= '0;
            bresp     <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: if (awvalid && awready) begin
                    wr_id     <= awid;
                    wr_addr   <= awaddr;
                    wr_len    <= awlen;
                    wr_size   <= awsize;
                    wr_burst  <= awburst;
                    wr_cnt    <= '0;
                    wr_err    <= burst_err(awaddr, awlen, awsize, awburst);
                    wlast_err <= 1'b0;
                end
                WR_DATA: if (wvalid) begin
                    if (wr_cnt == wr_len) begin
                        bid   <= wr_id;
                        bresp <= (wr_err || wlast_err || !wlast) ? SLVERR : OKAY;
                    end else begin
                        if (wlast)
                            wlast_err <= 1'b1;
                        wr_addr <= wr_step_addr;
                        wr_cnt  <= wr_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage array: not reset, so contents survive areset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b])
                    mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule
